// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch side:
// FSM state encoding, instruction word width and default memory geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 64;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word and keeps a running
// XOR checksum of every byte it has taken since the last clear.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic [7:0]        checksum
);

  logic [1:0]        lane_reg;
  logic [WORD_W-1:0] word_reg;
  logic [7:0]        checksum_reg;

  // 'word' already includes the byte being accepted, so the loader can
  // capture the complete word on the same edge as the 4th byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word[gi*8 +: 8] = (accept && (lane_reg == 2'(gi))) ? byte_data
                                                                 : word_reg[gi*8 +: 8];
    end
  endgenerate

  assign word_ready = accept && (lane_reg == 2'd3);
  assign checksum   = checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg     <= 2'd0;
      word_reg     <= '0;
      checksum_reg <= 8'd0;
    end else if (clear) begin
      lane_reg     <= 2'd0;
      word_reg     <= '0;
      checksum_reg <= 8'd0;
    end else if (accept) begin
      lane_reg     <= lane_reg + 2'd1;
      word_reg     <= word;
      checksum_reg <= checksum_reg ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction RAM
// from word 0 upward, holding the CPU until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        words_written
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t            state_reg, state_next;
  logic [7:0]        n_reg, n_next;
  logic [ADDR_W-1:0] addr_next;
  logic [WORD_W-1:0] wdata_next;
  logic [7:0]        ww_next;
  logic              we_next, hold_next, done_next, err_next;

  logic              accept, asm_clear, asm_accept, word_ready;
  logic [WORD_W-1:0] asm_word;
  logic [7:0]        checksum;

  assign byte_ready = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                      (state_reg == ST_CHECK);
  assign accept     = byte_valid && byte_ready;
  assign asm_accept = accept && (state_reg == ST_DATA);

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .accept     (asm_accept),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_ready (word_ready),
    .checksum   (checksum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    addr_next  = ram_addr;
    wdata_next = ram_wdata;
    ww_next    = words_written;
    we_next    = 1'b0;
    hold_next  = cpu_hold;
    done_next  = load_done;
    err_next   = load_err;
    asm_clear  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_next = ST_LEN;
          hold_next  = 1'b1;
          done_next  = 1'b0;
          err_next   = 1'b0;
          ww_next    = 8'd0;
          addr_next  = '0;
          asm_clear  = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if ((byte_data == 8'd0) || (byte_data > DEPTH_B)) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end else begin
            n_next     = byte_data;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_ready) begin
          wdata_next = asm_word;
          we_next    = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ww_next = words_written + 8'd1;
        if ((words_written + 8'd1) == n_reg) begin
          state_next = ST_CHECK;
        end else begin
          addr_next  = ram_addr + 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (byte_data == checksum) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg         <= 8'd0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      words_written <= 8'd0;
      ram_we        <= 1'b0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      n_reg         <= n_next;
      ram_addr      <= addr_next;
      ram_wdata     <= wdata_next;
      words_written <= ww_next;
      ram_we        <= we_next;
      cpu_hold      <= hold_next;
      load_done     <= done_next;
      load_err      <= err_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against an image-level
// model: expected RAM writes, checksum and final status.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [7:0]        words_written;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         log_q[$];
  logic [31:0] img[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The write port as the instruction RAM sees it; byte_ready must drop
  // exactly in the write cycles while a load is in flight.
  always @(negedge clk) begin
    if (rst_n && ram_we) log_q.push_back('{ram_addr, ram_wdata});
    if (chk_ready) check("ready_vs_we", 32'(byte_ready), 32'(!ram_we));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (byte_ready) begin
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        return;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [7:0] n, input bit bad_cks,
                          input int gap, input bit mid_start, input bit overlap);
    logic [7:0] cks;
    logic [7:0] b;
    bit         legal;
    int         nw;
    legal = (n != 8'd0) && (int'(n) <= DEPTH);
    log_q.delete();
    if (overlap) begin
      byte_valid = 1'b1;
      byte_data  = n;
    end
    pulse_start();
    check({tag, "_hold_start"}, 32'(cpu_hold), 32'd1);
    check({tag, "_ww_start"}, 32'(words_written), 32'd0);
    check({tag, "_flags_start"}, {30'd0, load_done, load_err}, 32'd0);
    chk_ready = 1'b1;
    send_byte(n, gap);
    if (!legal) begin
      chk_ready = 1'b0;
      check({tag, "_len_err"}, 32'(load_err), 32'd1);
      check({tag, "_len_done"}, 32'(load_done), 32'd0);
      check({tag, "_len_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_len_nowrite"}, 32'(log_q.size()), 32'd0);
      $display("load %s n=%0d writes=%0d done=%0d err=%0d", tag, n, log_q.size(), load_done, load_err);
      return;
    end
    cks = 8'd0;
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 0; k < 4; k++) begin
        b   = img[i][8*k +: 8];
        cks = cks ^ b;
        send_byte(b, gap);
        if (mid_start && i == 0 && k == 1) pulse_start();
      end
    end
    send_byte(bad_cks ? (cks ^ 8'h01) : cks, gap);
    chk_ready = 1'b0;
    check({tag, "_nwrites"}, 32'(log_q.size()), 32'(n));
    nw = (log_q.size() < int'(n)) ? log_q.size() : int'(n);
    for (int i = 0; i < nw; i++) begin
      check({tag, "_waddr"}, 32'(log_q[i].a), 32'(i));
      check({tag, "_wdata"}, log_q[i].d, img[i]);
    end
    check({tag, "_done"}, 32'(load_done), 32'(!bad_cks));
    check({tag, "_err"}, 32'(load_err), 32'(bad_cks));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(bad_cks));
    check({tag, "_ww"}, 32'(words_written), 32'(n));
    check({tag, "_addr_end"}, 32'(ram_addr), 32'(n - 8'd1));
    $display("load %s n=%0d writes=%0d done=%0d err=%0d", tag, n, log_q.size(), load_done, load_err);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, ram_wdata, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_ww"}, 32'(words_written), 32'd0);
  endtask

  task automatic random_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    logic [7:0] rn;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    img.delete();
    img.push_back(32'h1234_5678);
    img.push_back(32'hDEAD_BEEF);
    run_load("nominal", 8'd2, 1'b0, 0, 1'b0, 1'b0);
    run_load("badcks", 8'd2, 1'b1, 0, 1'b0, 1'b0);
    run_load("len00", 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_load("len41", 8'h41, 1'b0, 0, 1'b0, 1'b0);
    rn = 8'($urandom_range(255, 65));
    run_load("lenrand", rn, 1'b0, 2, 1'b0, 1'b0);
    run_load("stall", 8'd2, 1'b0, 5, 1'b1, 1'b0);
    run_load("overlap", 8'd2, 1'b0, 0, 1'b0, 1'b1);

    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(32'(i));
    run_load("full", 8'(DEPTH), 1'b0, 2, 1'b0, 1'b0);
    check("full_last_data", ram_wdata, 32'h0000_003F);

    // Abort a load after one and a half words, then reload from scratch.
    random_image(4);
    pulse_start();
    send_byte(8'd4, 1);
    for (int k = 0; k < 6; k++) send_byte(img[k / 4][8*(k % 4) +: 8], 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_load("after_reset", 8'd4, 1'b0, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rn = 8'($urandom_range(12, 1));
      random_image(int'(rn));
      run_load($sformatf("rand%0d", r), rn, ($urandom_range(3, 0) == 0), int'($urandom_range(3, 0)),
               ($urandom_range(1, 0) == 1), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
